// File: rtl/picobello_mesh_link.sv
// Multi-channel valid/ready mesh link.
// Each channel owns a small in-order FIFO with no fall-through path. A shared
// link state machine gates upstream acceptance: DISABLED swallows (and counts)
// upstream flits, ENABLED buffers them, DRAINING refuses new flits while the
// FIFOs empty towards the downstream. Saturating statistics counters track
// delivered and discarded flits per channel.
module picobello_mesh_link #(
  parameter int unsigned NumChan   = 3,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 2,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                en_i,
  input  logic                                clr_i,
  input  logic [NumChan-1:0]                  valid_i,
  output logic [NumChan-1:0]                  ready_o,
  input  logic [NumChan-1:0][DataWidth-1:0]   data_i,
  output logic [NumChan-1:0]                  valid_o,
  input  logic [NumChan-1:0]                  ready_i,
  output logic [NumChan-1:0][DataWidth-1:0]   data_o,
  output logic [1:0]                          state_o,
  output logic [NumChan-1:0][CntWidth-1:0]    flit_cnt_o,
  output logic [NumChan-1:0][CntWidth-1:0]    drop_cnt_o,
  output logic                                empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned OccW = $clog2(Depth + 1);

  typedef enum logic [1:0] {
    StDisabled = 2'd0,
    StEnabled  = 2'd1,
    StDraining = 2'd2
  } state_e;

  state_e             state_q;
  logic [NumChan-1:0] fifo_empty;
  logic               all_empty;

  // Counters stick at their maximum instead of wrapping.
  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + CntWidth'(1);
  endfunction

  // Circular pointer advance that wraps at the last entry.
  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign all_empty = &fifo_empty;
  assign empty_o   = all_empty;
  assign state_o   = state_q;

  // Link state machine; DRAINING only exits to DISABLED once every FIFO is empty,
  // so a flit accepted in the last ENABLED cycle is always delivered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StDisabled;
    end else begin
      unique case (state_q)
        StDisabled: if (en_i) state_q <= StEnabled;
        StEnabled:  if (!en_i) state_q <= StDraining;
        StDraining: begin
          if (en_i)           state_q <= StEnabled;
          else if (all_empty) state_q <= StDisabled;
        end
        default:    state_q <= StDisabled;
      endcase
    end
  end

  for (genvar c = 0; c < NumChan; c++) begin : gen_chan
    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      rd_ptr_q;
    logic [PtrW-1:0]      wr_ptr_q;
    logic [OccW-1:0]      occ_q;
    logic [CntWidth-1:0]  flit_cnt_q;
    logic [CntWidth-1:0]  drop_cnt_q;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 drop;

    assign full          = (occ_q == OccW'(Depth));
    assign fifo_empty[c] = (occ_q == '0);

    // Ready is a function of registered state and occupancy only.
    assign ready_o[c] = (state_q == StDisabled) | ((state_q == StEnabled) & ~full);
    assign valid_o[c] = ~fifo_empty[c];
    assign data_o[c]  = mem_q[rd_ptr_q];

    assign push = (state_q == StEnabled) & valid_i[c] & ~full;
    assign pop  = valid_o[c] & ready_i[c];
    assign drop = (state_q == StDisabled) & valid_i[c];

    assign flit_cnt_o[c] = flit_cnt_q;
    assign drop_cnt_o[c] = drop_cnt_q;

    // Payload storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= data_i[c];
    end

    // FIFO pointers and occupancy; reset empties the FIFO without emitting anything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        occ_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
        if (push && !pop)      occ_q <= occ_q + OccW'(1);
        else if (pop && !push) occ_q <= occ_q - OccW'(1);
      end
    end

    // Statistics; a clear takes priority over any same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        flit_cnt_q <= '0;
        drop_cnt_q <= '0;
      end else if (clr_i) begin
        flit_cnt_q <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (pop)  flit_cnt_q <= sat_inc(flit_cnt_q);
        if (drop) drop_cnt_q <= sat_inc(drop_cnt_q);
      end
    end
  end

endmodule

// File: tb/tb_picobello_mesh_link.sv
// Bench for picobello_mesh_link: a reference model tracks expected FIFO contents,
// link state and counters; a monitor on the falling edge compares every output.
// Directed phases add hand-derived checks on latency, back-pressure, draining,
// drop counting, reset and counter saturation/clear.
module tb_picobello_mesh_link;

  localparam int NC = 3;
  localparam int DW = 16;
  localparam int D  = 2;
  localparam int CW = 16;

  localparam logic [1:0] S_DIS = 2'd0;
  localparam logic [1:0] S_EN  = 2'd1;
  localparam logic [1:0] S_DR  = 2'd2;

  logic                      clk = 1'b0;
  logic                      rst_ni;
  logic                      en_i;
  logic                      clr_i;
  logic [NC-1:0]             valid_i;
  logic [NC-1:0]             ready_o;
  logic [NC-1:0][DW-1:0]     data_i;
  logic [NC-1:0]             valid_o;
  logic [NC-1:0]             ready_i;
  logic [NC-1:0][DW-1:0]     data_o;
  logic [1:0]                state_o;
  logic [NC-1:0][CW-1:0]     flit_cnt_o;
  logic [NC-1:0][CW-1:0]     drop_cnt_o;
  logic                      empty_o;

  // Second instance with narrow counters for saturation and clear checks.
  logic                      s_en;
  logic                      s_clr;
  logic [0:0]                s_valid_i;
  logic [0:0]                s_ready_o;
  logic [0:0][DW-1:0]        s_data_i;
  logic [0:0]                s_valid_o;
  logic [0:0]                s_ready_i;
  logic [0:0][DW-1:0]        s_data_o;
  logic [1:0]                s_state_o;
  logic [0:0][1:0]           s_flit_cnt;
  logic [0:0][1:0]           s_drop_cnt;
  logic                      s_empty;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [DW-1:0]  m_q [NC][$];
  logic [1:0]     m_state;
  logic [CW-1:0]  m_flit [NC];
  logic [CW-1:0]  m_drop [NC];

  picobello_mesh_link #(.NumChan(NC), .DataWidth(DW), .Depth(D), .CntWidth(CW)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .clr_i(clr_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .state_o(state_o), .flit_cnt_o(flit_cnt_o), .drop_cnt_o(drop_cnt_o),
    .empty_o(empty_o)
  );

  picobello_mesh_link #(.NumChan(1), .DataWidth(DW), .Depth(2), .CntWidth(2)) u_sat (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(s_en), .clr_i(s_clr),
    .valid_i(s_valid_i), .ready_o(s_ready_o), .data_i(s_data_i),
    .valid_o(s_valid_o), .ready_i(s_ready_i), .data_o(s_data_o),
    .state_o(s_state_o), .flit_cnt_o(s_flit_cnt), .drop_cnt_o(s_drop_cnt),
    .empty_o(s_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [CW-1:0] msat(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Monitor: compare DUT against the model, then advance the model to the
  // values expected after the coming rising edge.
  always @(negedge clk) begin
    logic          all_empty;
    logic [NC-1:0] exp_valid;
    logic [NC-1:0] exp_ready;
    if (!rst_ni) begin
      for (int c = 0; c < NC; c++) begin
        m_q[c].delete();
        m_flit[c] = '0;
        m_drop[c] = '0;
      end
      m_state = S_DIS;
      chk("rst valid_o", 64'(valid_o), 64'(0));
      chk("rst ready_o", 64'(ready_o), 64'({NC{1'b1}}));
      chk("rst state_o", 64'(state_o), 64'(S_DIS));
      chk("rst empty_o", 64'(empty_o), 64'(1));
    end else begin
      all_empty = 1'b1;
      for (int c = 0; c < NC; c++) begin
        exp_valid[c] = (m_q[c].size() > 0);
        if (exp_valid[c]) all_empty = 1'b0;
        exp_ready[c] = (m_state == S_DIS) ? 1'b1 :
                       (m_state == S_EN)  ? (m_q[c].size() < D) : 1'b0;
      end
      chk("valid_o", 64'(valid_o), 64'(exp_valid));
      chk("ready_o", 64'(ready_o), 64'(exp_ready));
      chk("state_o", 64'(state_o), 64'(m_state));
      chk("empty_o", 64'(empty_o), 64'(all_empty));
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("flit_cnt_o[%0d]", c), 64'(flit_cnt_o[c]), 64'(m_flit[c]));
        chk($sformatf("drop_cnt_o[%0d]", c), 64'(drop_cnt_o[c]), 64'(m_drop[c]));
        if (exp_valid[c]) chk($sformatf("data_o[%0d]", c), 64'(data_o[c]), 64'(m_q[c][0]));
      end
      for (int c = 0; c < NC; c++) begin
        logic pop, push, drop;
        pop  = exp_valid[c] && ready_i[c];
        push = (m_state == S_EN) && valid_i[c] && (m_q[c].size() < D);
        drop = (m_state == S_DIS) && valid_i[c];
        if (pop)  void'(m_q[c].pop_front());
        if (push) m_q[c].push_back(data_i[c]);
        if (clr_i) begin
          m_flit[c] = '0;
          m_drop[c] = '0;
        end else begin
          if (pop)  m_flit[c] = msat(m_flit[c]);
          if (drop) m_drop[c] = msat(m_drop[c]);
        end
      end
      case (m_state)
        S_DIS:   if (en_i) m_state = S_EN;
        S_EN:    if (!en_i) m_state = S_DR;
        default: if (en_i) m_state = S_EN; else if (all_empty) m_state = S_DIS;
      endcase
    end
  end

  initial begin
    rst_ni = 1'b0; en_i = 1'b0; clr_i = 1'b0;
    valid_i = '0; data_i = '0; ready_i = '1;
    s_en = 1'b0; s_clr = 1'b0; s_valid_i = '0; s_data_i = '0; s_ready_i = '1;
    step(3);
    chk("reset state_o", 64'(state_o), 64'(0));
    chk("reset ready_o", 64'(ready_o), 64'(3'b111));
    chk("reset empty_o", 64'(empty_o), 64'(1));

    // Streaming on ch0 with the link requested from reset release.
    en_i = 1'b1; valid_i = 3'b001; data_i[0] = 16'h0;
    rst_ni = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      if (i == 1) chk("first valid_o[0] early", 64'(valid_o[0]), 64'(0));
      if (i == 2) chk("first valid_o[0] at +2", 64'(valid_o[0]), 64'(1));
      data_i[0] = data_i[0] + 16'h1;
    end
    valid_i = '0;
    step(4);
    chk("stream flit_cnt_o[0]", 64'(flit_cnt_o[0]), 64'(5));
    chk("stream drop_cnt_o[0]", 64'(drop_cnt_o[0]), 64'(1));

    // Back-pressure on ch1.
    ready_i = 3'b101; valid_i = 3'b010; data_i[1] = 16'h100;
    step(1); data_i[1] = 16'h101;
    step(1); data_i[1] = 16'h102;
    chk("bp ready_o[1] full", 64'(ready_o[1]), 64'(0));
    step(2);
    chk("bp data_o[1] stable", 64'(data_o[1]), 64'(16'h100));
    chk("bp ready_o[1] held", 64'(ready_o[1]), 64'(0));
    ready_i = 3'b111;
    step(2); valid_i = '0;
    step(3);
    chk("bp flit_cnt_o[1]", 64'(flit_cnt_o[1]), 64'(3));

    // Drain two flits on ch2 after the link is released.
    ready_i = 3'b011; valid_i = 3'b100; data_i[2] = 16'h200;
    step(1); data_i[2] = 16'h201;
    step(1); valid_i = '0;
    chk("drain valid_o[2] buffered", 64'(valid_o[2]), 64'(1));
    en_i = 1'b0; ready_i = 3'b111;
    step(1);
    chk("drain state_o", 64'(state_o), 64'(2));
    chk("drain ready_o", 64'(ready_o), 64'(0));
    step(1);
    chk("drain state_o still", 64'(state_o), 64'(2));
    step(1);
    chk("drain done state_o", 64'(state_o), 64'(0));
    chk("drain done empty_o", 64'(empty_o), 64'(1));
    chk("drain flit_cnt_o[2]", 64'(flit_cnt_o[2]), 64'(2));

    // Empty link still spends one cycle in DRAINING.
    en_i = 1'b1; step(1);
    chk("reenable state_o", 64'(state_o), 64'(1));
    en_i = 1'b0; step(1);
    chk("empty drain state_o", 64'(state_o), 64'(2));
    step(1);
    chk("empty drain exit", 64'(state_o), 64'(0));

    // Drops while disabled, from a fresh reset.
    rst_ni = 1'b0; step(2); rst_ni = 1'b1;
    valid_i = 3'b001; data_i[0] = 16'hdead;
    step(5); valid_i = '0;
    step(1);
    chk("dis drop_cnt_o[0]", 64'(drop_cnt_o[0]), 64'(5));
    chk("dis flit_cnt_o[0]", 64'(flit_cnt_o[0]), 64'(0));
    chk("dis valid_o", 64'(valid_o), 64'(0));

    // Reset with flits buffered.
    en_i = 1'b1; ready_i = 3'b110;
    step(1);
    valid_i = 3'b001; data_i[0] = 16'h300;
    step(1); data_i[0] = 16'h301;
    step(1); valid_i = '0;
    chk("prerst valid_o[0]", 64'(valid_o[0]), 64'(1));
    chk("prerst empty_o", 64'(empty_o), 64'(0));
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst valid_o", 64'(valid_o), 64'(0));
    chk("midrst state_o", 64'(state_o), 64'(0));
    chk("midrst drop_cnt_o[0]", 64'(drop_cnt_o[0]), 64'(0));
    en_i = 1'b0; ready_i = 3'b111;
    step(2); rst_ni = 1'b1;

    // Narrow-counter instance: saturation and clear against a delivery.
    s_en = 1'b1; s_valid_i = 1'b1; s_data_i[0] = 16'h10;
    step(6); s_valid_i = 1'b0;
    step(2);
    chk("sat flit_cnt", 64'(s_flit_cnt[0]), 64'(3));
    chk("sat drop_cnt", 64'(s_drop_cnt[0]), 64'(1));
    s_valid_i = 1'b1; s_data_i[0] = 16'h55;
    step(1); s_valid_i = 1'b0; s_clr = 1'b1;
    chk("clr pre valid_o", 64'(s_valid_o[0]), 64'(1));
    chk("clr pre data_o", 64'(s_data_o[0]), 64'(16'h55));
    step(1); s_clr = 1'b0;
    chk("clr flit_cnt", 64'(s_flit_cnt[0]), 64'(0));
    chk("clr drop_cnt", 64'(s_drop_cnt[0]), 64'(0));
    chk("clr state kept", 64'(s_state_o), 64'(1));
    chk("clr flit delivered", 64'(s_valid_o[0]), 64'(0));

    step(3);
    for (int c = 0; c < NC; c++)
      chk($sformatf("leftover flits ch%0d", c), 64'(m_q[c].size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
